// File: rtl/wb_burst_master_if.sv
// Wishbone B3 bus bundle between wb_burst_master and an SDRAM controller slave.
// Ports: master drives cyc/stb/we/cti/adr/dat_o/sel; slave returns ack/dat_i.
interface wb_burst_master_if #(
  parameter int AW = 26,
  parameter int DW = 32
);
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [2:0]      wb_cti_o;
  logic [AW-1:0]   wb_adr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic            wb_ack_i;
  logic [DW-1:0]   wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o,
    output wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o,
    input  wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_ack_i, wb_dat_i
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B3 burst master: one (addr, len, we, sel) command becomes a
// classic single cycle (len 0) or an incrementing burst (CTI 010 .. 111).
// Ports: sys_clk, wb_rst_i (sync, active-high); cmd_* command stream;
// wr_valid/wr_ready/wr_data write beats in; rd_valid/rd_data read beats out;
// done/err completion pulse; wb = Wishbone master modport.
// Optional watchdog abort is enabled by defining WB_TIMEOUT_EN.
module wb_burst_master #(
  parameter int APP_AW  = 26,
  parameter int dw      = 32,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              sys_clk,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [dw/8-1:0]   cmd_sel,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [dw-1:0]     wr_data,
  output logic              rd_valid,
  output logic [dw-1:0]     rd_data,
  output logic              done,
  output logic              err,
  wb_burst_master_if.master wb
);

  localparam int LW = LEN_W + 1;
  localparam logic [APP_AW-1:0] ADR_INC = APP_AW'(dw / 8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [APP_AW-1:0] adr_q, adr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LW-1:0]     load_q, load_d;
  logic              we_q, we_d;
  logic [dw/8-1:0]   sel_q, sel_d;
  logic              cls_q, cls_d;
  logic              full_q, full_d;
  logic [dw-1:0]     dat_q, dat_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic [2:0]        cti_q, cti_d;
  logic              rdv_q, rdv_d;
  logic [dw-1:0]     rdd_q, rdd_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rdy_q, rdy_d;

  logic beat;
  logic take;
  logic abort;

  assign beat = cyc_q && stb_q && wb.wb_ack_i;

  // Refill of the holding register may coincide with the beat that empties it.
  assign wr_ready = (state_q == S_BURST) && we_q &&
                    (load_q != '0) && (!full_q || beat);
  assign take     = wr_valid && wr_ready;

`ifdef WB_TIMEOUT_EN
  localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [WDW-1:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d = wdog_q;
    if (state_q != S_BURST || beat) begin
      wdog_d = '0;
    end else if (stb_q) begin
      wdog_d = wdog_q + WDW'(1);
    end
  end

  // This cycle is the TIMEOUT-th stb cycle without ack.
  assign abort = (state_q == S_BURST) && stb_q && !wb.wb_ack_i &&
                 (wdog_q == WDW'(TIMEOUT - 1));

  always_ff @(posedge sys_clk) begin
    if (wb_rst_i) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign abort          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    cnt_d   = cnt_q;
    load_d  = load_q;
    we_d    = we_q;
    sel_d   = sel_q;
    cls_d   = cls_q;
    full_d  = full_q;
    dat_d   = dat_q;
    cyc_d   = cyc_q;
    cti_d   = cti_q;
    rdv_d   = 1'b0;
    rdd_d   = rdd_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdy_d   = rdy_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && rdy_q) begin
          state_d = S_BURST;
          adr_d   = cmd_addr;
          cnt_d   = cmd_len;
          load_d  = {1'b0, cmd_len} + LW'(1);
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          cls_d   = (cmd_len == '0);
          cti_d   = (cmd_len == '0) ? 3'b000 : 3'b010;
          full_d  = 1'b0;
          cyc_d   = 1'b1;
          rdy_d   = 1'b0;
        end
      end

      S_BURST: begin
        if (beat) begin
          adr_d = adr_q + ADR_INC;
          cnt_d = cnt_q - LEN_W'(1);
          if (!cls_q) begin
            cti_d = (cnt_q == LEN_W'(1)) ? 3'b111 : 3'b010;
          end
          if (!we_q) begin
            rdv_d = 1'b1;
            rdd_d = wb.wb_dat_i;
          end
        end
        if (take) begin
          dat_d  = wr_data;
          full_d = 1'b1;
          load_d = load_q - LW'(1);
        end else if (beat) begin
          full_d = 1'b0;
        end
        if ((beat && cnt_q == '0) || abort) begin
          state_d = S_DONE;
          cyc_d   = 1'b0;
          full_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = abort;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        rdy_d   = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        full_d  = 1'b0;
        rdy_d   = 1'b1;
      end
    endcase

    // Reads strobe for the whole burst; writes only while data is held.
    stb_d = (state_d == S_BURST) && (we_d ? full_d : 1'b1);
  end

  always_ff @(posedge sys_clk) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      cnt_q   <= '0;
      load_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      cls_q   <= 1'b0;
      full_q  <= 1'b0;
      dat_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      cti_q   <= 3'b000;
      rdv_q   <= 1'b0;
      rdd_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      cls_q   <= cls_d;
      full_q  <= full_d;
      dat_q   <= dat_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      cti_q   <= cti_d;
      rdv_q   <= rdv_d;
      rdd_q   <= rdd_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign cmd_ready   = rdy_q;
  assign rd_valid    = rdv_q;
  assign rd_data     = rdd_q;
  assign done        = done_q;
  assign err         = err_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_cti_o = cti_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = sel_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: single write, wrapping read burst,
// write burst with source stall, reset mid-burst, no-ack behaviour.
module tb_wb_burst_master;

  logic        sys_clk = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [25:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [3:0]  cmd_sel;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  wb_burst_master_if #(.AW(26), .DW(32)) wb ();

  wb_burst_master #(
    .APP_AW (26),
    .dw     (32),
    .LEN_W  (8),
    .TIMEOUT(16)
  ) dut (
    .sys_clk  (sys_clk),
    .wb_rst_i (wb_rst_i),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .cmd_sel  (cmd_sel),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .done     (done),
    .err      (err),
    .wb       (wb)
  );

  always #5 sys_clk = ~sys_clk;

  // Slave: zero-wait ack while enabled; read data derived from address.
  logic ack_en;
  assign wb.wb_ack_i = ack_en && wb.wb_cyc_o && wb.wb_stb_o;
  assign wb.wb_dat_i = {6'b0, wb.wb_adr_o} ^ 32'hC0DE0000;

  // Write-data source with a programmable 3-cycle stall.
  logic [31:0] src_mem [0:15];
  int          src_idx = 0;
  int          src_lim;
  int          gap_at;
  int          gap_cnt = 0;

  assign wr_valid = (src_idx < src_lim) && (gap_cnt == 0);
  assign wr_data  = src_mem[src_idx[3:0]];

  always @(posedge sys_clk) begin
    if (wr_valid && wr_ready) begin
      src_idx <= src_idx + 1;
      if (src_idx == gap_at) gap_cnt <= 3;
    end else if (gap_cnt != 0) begin
      gap_cnt <= gap_cnt - 1;
    end
  end

  // Bus / stream monitor, sampled mid-cycle.
  logic [25:0] b_adr [0:63];
  logic [2:0]  b_cti [0:63];
  logic [31:0] b_dat [0:63];
  logic [3:0]  b_sel [0:63];
  logic        b_we  [0:63];
  logic [31:0] r_dat [0:63];
  int nb = 0, nr = 0, ndone = 0, nwait = 0, nstb = 0, nerr = 0;
  logic last_err = 1'b0;
  logic done_cyc = 1'b0;

  always @(negedge sys_clk) begin
    if (wb.wb_cyc_o && wb.wb_stb_o && wb.wb_ack_i && nb < 64) begin
      b_adr[nb] <= wb.wb_adr_o;
      b_cti[nb] <= wb.wb_cti_o;
      b_dat[nb] <= wb.wb_dat_o;
      b_sel[nb] <= wb.wb_sel_o;
      b_we[nb]  <= wb.wb_we_o;
      nb <= nb + 1;
    end
    if (rd_valid && nr < 64) begin
      r_dat[nr] <= rd_data;
      nr <= nr + 1;
    end
    if (done) begin
      ndone    <= ndone + 1;
      last_err <= err;
      done_cyc <= wb.wb_cyc_o;
    end
    if (err) nerr <= nerr + 1;
    if (wb.wb_cyc_o && !wb.wb_stb_o) nwait <= nwait + 1;
    if (wb.wb_cyc_o && wb.wb_stb_o) nstb <= nstb + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [25:0] a,
                       input logic [7:0] l, input logic [3:0] s);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    chk("cmd_ready_before_issue", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_sel   = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = ndone;
    n  = 0;
    while (ndone == d0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, ndone - d0, 32'd1);
  endtask

  logic [25:0] e_radr [0:3];
  logic [2:0]  e_rcti [0:3];
  logic [31:0] e_rdat [0:3];

  initial begin
    int b0, r0, w0, d0, s0, n;

    e_radr[0] = 26'h3FFFFF8; e_rdat[0] = 32'hC321FFF8; e_rcti[0] = 3'b010;
    e_radr[1] = 26'h3FFFFFC; e_rdat[1] = 32'hC321FFFC; e_rcti[1] = 3'b010;
    e_radr[2] = 26'h0000000; e_rdat[2] = 32'hC0DE0000; e_rcti[2] = 3'b010;
    e_radr[3] = 26'h0000004; e_rdat[3] = 32'hC0DE0004; e_rcti[3] = 3'b111;

    src_mem[0] = 32'hA5A5A5A5;
    for (int i = 0; i < 8; i++) src_mem[1+i] = 32'h1000_0000 + i;
    for (int i = 9; i < 16; i++) src_mem[i] = 32'hDEAD_0000 + i;

    wb_rst_i  = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_sel   = '0;
    ack_en    = 1'b1;
    src_lim   = 0;
    gap_at    = 2;

    // Reset values
    repeat (3) tick();
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_cyc", {31'b0, wb.wb_cyc_o}, 32'd0);
    chk("rst_stb", {31'b0, wb.wb_stb_o}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst_cti", {29'b0, wb.wb_cti_o}, 32'd0);
    chk("rst_adr", {6'b0, wb.wb_adr_o}, 32'd0);
    wb_rst_i = 1'b0;
    tick();

    // Write data offered in IDLE is not taken
    src_lim = 1;
    #1;
    chk("idle_wr_ready", {31'b0, wr_ready}, 32'd0);
    tick();
    chk("idle_src_idx", src_idx, 32'd0);

    // Single classic write
    b0 = nb;
    issue(1'b1, 26'h100, 8'd0, 4'hF);
    wait_done("t1_done", 20);
    chk("t1_beats", nb - b0, 32'd1);
    chk("t1_adr", {6'b0, b_adr[b0]}, 32'h100);
    chk("t1_cti", {29'b0, b_cti[b0]}, 32'd0);
    chk("t1_dat", b_dat[b0], 32'hA5A5A5A5);
    chk("t1_sel", {28'b0, b_sel[b0]}, 32'hF);
    chk("t1_we", {31'b0, b_we[b0]}, 32'd1);
    chk("t1_err", {31'b0, last_err}, 32'd0);
    chk("t1_src_used", src_idx, 32'd1);

    // Read burst wrapping the top of the address space
    b0 = nb;
    r0 = nr;
    issue(1'b0, 26'h3FFFFF8, 8'd3, 4'hF);
    wait_done("t2_done", 30);
    chk("t2_beats", nb - b0, 32'd4);
    chk("t2_rd_pulses", nr - r0, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_adr%0d", i), {6'b0, b_adr[b0+i]}, {6'b0, e_radr[i]});
      chk($sformatf("t2_cti%0d", i), {29'b0, b_cti[b0+i]}, {29'b0, e_rcti[i]});
      chk($sformatf("t2_rd%0d", i), r_dat[r0+i], e_rdat[i]);
    end
    chk("t2_err", {31'b0, last_err}, 32'd0);

    // Write burst with a 3-cycle source stall after the second word
    b0 = nb;
    w0 = nwait;
    src_lim = 9;
    issue(1'b1, 26'h200, 8'd7, 4'h3);
    wait_done("t3_done", 60);
    chk("t3_beats", nb - b0, 32'd8);
    // one initial load cycle plus the three stalled cycles
    chk("t3_wait_cycles", nwait - w0, 32'd4);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_dat%0d", i), b_dat[b0+i], 32'h1000_0000 + i);
      chk($sformatf("t3_adr%0d", i), {6'b0, b_adr[b0+i]}, 32'h200 + 4*i);
      chk($sformatf("t3_cti%0d", i), {29'b0, b_cti[b0+i]},
          (i == 7) ? 32'd7 : 32'd2);
    end
    chk("t3_sel", {28'b0, b_sel[b0+3]}, 32'h3);
    chk("t3_err", {31'b0, last_err}, 32'd0);

    // Reset on beat 5 of a 16-beat read
    b0 = nb;
    r0 = nr;
    d0 = ndone;
    issue(1'b0, 26'h1000, 8'd15, 4'hF);
    n = 0;
    while (nb - b0 < 4 && n < 30) begin
      tick();
      n++;
    end
    chk("t4_reached_beat5", nb - b0, 32'd4);
    wb_rst_i = 1'b1;
    tick();
    chk("t4_cyc_released", {31'b0, wb.wb_cyc_o}, 32'd0);
    chk("t4_stb_released", {31'b0, wb.wb_stb_o}, 32'd0);
    chk("t4_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("t4_done_low", {31'b0, done}, 32'd0);
    wb_rst_i = 1'b0;
    repeat (3) tick();
    chk("t4_no_done", ndone - d0, 32'd0);
    chk("t4_beats", nb - b0, 32'd5);
    chk("t4_rd_pulses", nr - r0, 32'd4);

    b0 = nb;
    r0 = nr;
    issue(1'b0, 26'h40, 8'd1, 4'hF);
    wait_done("t4b_done", 20);
    chk("t4b_beats", nb - b0, 32'd2);
    chk("t4b_adr1", {6'b0, b_adr[b0+1]}, 32'h44);
    chk("t4b_cti0", {29'b0, b_cti[b0]}, 32'd2);
    chk("t4b_cti1", {29'b0, b_cti[b0+1]}, 32'd7);
    chk("t4b_rd0", r_dat[r0], 32'hC0DE0040);
    chk("t4b_rd1", r_dat[r0+1], 32'hC0DE0044);
    chk("t4b_err", {31'b0, last_err}, 32'd0);

    // Slave that never acks
    ack_en = 1'b0;
    s0 = nstb;
    d0 = ndone;
    issue(1'b0, 26'h80, 8'd0, 4'hF);
`ifdef WB_TIMEOUT_EN
    wait_done("t5_done", 40);
    chk("t5_stb_cycles", nstb - s0, 32'd16);
    chk("t5_err", {31'b0, last_err}, 32'd1);
    chk("t5_cyc_at_done", {31'b0, done_cyc}, 32'd0);
    chk("t5_cyc_after", {31'b0, wb.wb_cyc_o}, 32'd0);
`else
    repeat (100) tick();
    chk("t5_cyc_held", {31'b0, wb.wb_cyc_o}, 32'd1);
    chk("t5_stb_held", {31'b0, wb.wb_stb_o}, 32'd1);
    chk("t5_no_done", ndone - d0, 32'd0);
    chk("t5_err_never", nerr, 32'd0);
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    chk("t5_cyc_after_rst", {31'b0, wb.wb_cyc_o}, 32'd0);
`endif
    ack_en = 1'b1;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
